// File: rtl/exe_muldiv_unit_if.sv
// Handshake and result bus between the execute stage and the multi-cycle mul/div unit.
// Vectors use the pipeline's [0:N] numbering: bit 0 is the MSB.
interface exe_muldiv_unit_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 7
);
  logic               in_valid;
  logic               in_ready;
  logic [0:1]         in_op;
  logic [0:WIDTH-1]   in_a;
  logic [0:WIDTH-1]   in_b;
  logic [0:TAG_W-1]   in_tag;
  logic               flush;
  logic               out_stall;
  logic               out_valid;
  logic [0:WIDTH-1]   out_lo;
  logic [0:WIDTH-1]   out_hi;
  logic [0:TAG_W-1]   out_tag;
  logic               out_div_zero;

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, flush, out_stall,
    input  in_ready, out_valid, out_lo, out_hi, out_tag, out_div_zero
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, flush, out_stall,
    output in_ready, out_valid, out_lo, out_hi, out_tag, out_div_zero
  );
endinterface

// File: rtl/exe_muldiv_unit.sv
// Iterative multiply/divide unit: one result bit per cycle on operand magnitudes,
// signs applied in a final fix-up cycle, result held with its tag until taken.
module exe_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 7
) (
  input logic              clk,
  input logic              reset,
  exe_muldiv_unit_if.slave bus
);
  // state | meaning
  // IDLE  | ready, waiting for an operation
  // BUSY  | one shift-add / shift-subtract step per cycle
  // FIX   | apply signs, load result registers
  // DONE  | result presented until downstream takes it
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   count;
  logic               is_div, neg_res, neg_rem, div_zero;
  logic [TAG_W-1:0]   tag_q;
  logic [WIDTH-1:0]   opnd, acc_hi, acc_lo;
  logic [WIDTH-1:0]   out_lo_q, out_hi_q;
  logic [TAG_W-1:0]   out_tag_q;
  logic               out_dz_q;

  logic [1:0]         op_in;
  logic [WIDTH-1:0]   a_in, b_in, a_mag, b_mag;
  logic               a_neg, b_neg, accept;

  assign op_in  = bus.in_op;
  assign a_in   = bus.in_a;
  assign b_in   = bus.in_b;
  assign a_neg  = op_in[0] & a_in[WIDTH-1];
  assign b_neg  = op_in[0] & b_in[WIDTH-1];
  // Magnitude of the most-negative value is 2^(WIDTH-1), still exact as unsigned.
  assign a_mag  = a_neg ? -a_in : a_in;
  assign b_mag  = b_neg ? -b_in : b_in;
  assign accept = (state == IDLE) && bus.in_valid && !bus.flush;

  // Per-cycle step; the mul sum carries one extra bit that shifts into acc_hi.
  logic [WIDTH:0]     mul_sum, rem_sh, rem_diff;
  logic               rem_ge;
  logic [WIDTH-1:0]   step_hi, step_lo;

  always_comb begin
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    rem_sh   = {acc_hi, acc_lo[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, opnd};
    rem_ge   = (rem_sh >= {1'b0, opnd});
    if (is_div) begin
      step_hi = rem_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], rem_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign prod     = {acc_hi, acc_lo};
  assign prod_fix = neg_res ? -prod : prod;
  assign quo_fix  = div_zero ? {WIDTH{1'b1}} : (neg_res ? -acc_lo : acc_lo);
  assign rem_fix  = neg_rem ? -acc_hi : acc_hi;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = BUSY;
      BUSY: begin
        if (bus.flush)                   state_nxt = IDLE;
        else if (count == CNT_W'(1))     state_nxt = FIX;
      end
      FIX:  state_nxt = bus.flush ? IDLE : DONE;
      DONE: if (bus.flush || !bus.out_stall) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count     <= '0;
      is_div    <= 1'b0;
      neg_res   <= 1'b0;
      neg_rem   <= 1'b0;
      div_zero  <= 1'b0;
      tag_q     <= '0;
      opnd      <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      out_lo_q  <= '0;
      out_hi_q  <= '0;
      out_tag_q <= '0;
      out_dz_q  <= 1'b0;
    end else begin
      if (accept) begin
        is_div   <= op_in[1];
        neg_res  <= a_neg ^ b_neg;
        neg_rem  <= a_neg;
        div_zero <= op_in[1] && (b_in == '0);
        tag_q    <= bus.in_tag;
        count    <= CNT_W'(WIDTH);
        acc_hi   <= '0;
        if (op_in[1]) begin
          acc_lo <= a_mag;
          opnd   <= b_mag;
        end else begin
          acc_lo <= b_mag;
          opnd   <= a_mag;
        end
      end else if (state == BUSY) begin
        count  <= count - CNT_W'(1);
        acc_hi <= step_hi;
        acc_lo <= step_lo;
      end

      if ((state == FIX) && !bus.flush) begin
        out_tag_q <= tag_q;
        out_dz_q  <= div_zero;
        if (is_div) begin
          out_lo_q <= quo_fix;
          out_hi_q <= rem_fix;
        end else begin
          out_lo_q <= prod_fix[WIDTH-1:0];
          out_hi_q <= prod_fix[2*WIDTH-1:WIDTH];
        end
      end
    end
  end

  assign bus.in_ready     = (state == IDLE);
  assign bus.out_valid    = (state == DONE);
  assign bus.out_lo       = out_lo_q;
  assign bus.out_hi       = out_hi_q;
  assign bus.out_tag      = out_tag_q;
  assign bus.out_div_zero = out_dz_q;
endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Bench for exe_muldiv_unit: directed corner cases plus random ops against an arithmetic model.
`timescale 1ns/1ps
module tb_exe_muldiv_unit;
  localparam int WIDTH = 32;
  localparam int TAG_W = 7;
  localparam int LAT   = WIDTH + 1;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [31:0] last_lo = '0;
  logic [31:0] last_hi = '0;

  exe_muldiv_unit_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

  exe_muldiv_unit #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on 64-bit values.
  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] lo, output logic [31:0] hi, output logic dz);
    longint      sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    p  = '0;
    case (op)
      2'b00: begin
        p  = {32'h0, a} * {32'h0, b};
        lo = p[31:0];
        hi = p[63:32];
      end
      2'b01: begin
        p  = sa * sb;
        lo = p[31:0];
        hi = p[63:32];
      end
      default: begin
        if (b == 32'h0) begin
          lo = 32'hFFFF_FFFF;
          hi = a;
          dz = 1'b1;
        end else if (op == 2'b10) begin
          lo = a / b;
          hi = a % b;
        end else begin
          lo = 32'(sa / sb);
          hi = 32'(sa % sb);
        end
      end
    endcase
  endtask

  task automatic quiet(input string tag, input int cycles);
    int seen;
    seen = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    chk(tag, seen, 0);
  endtask

  task automatic drive_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [6:0] tag);
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_tag   = tag;
    bus.in_valid = 1'b1;
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [6:0] tag,
                        input int stall_cyc, input bit flush_done);
    logic [31:0] elo, ehi;
    logic        edz;
    int          n;
    model(op, a, b, elo, ehi, edz);
    @(negedge clk);
    chk({name, "_ready"}, bus.in_ready, 1);
    drive_op(op, a, b, tag);
    bus.out_stall = (stall_cyc > 0) || flush_done;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == 1) chk({name, "_busy_ready"}, bus.in_ready, 0);
    end while (!bus.out_valid && n < 200);
    chk({name, "_lat"}, n, LAT);
    chk({name, "_lo"}, bus.out_lo, elo);
    chk({name, "_hi"}, bus.out_hi, ehi);
    chk({name, "_tag"}, bus.out_tag, tag);
    chk({name, "_dz"}, bus.out_div_zero, edz);
    for (int k = 0; k < stall_cyc; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk({name, "_hold_valid"}, bus.out_valid, 1);
      chk({name, "_hold_lo"}, bus.out_lo, elo);
      chk({name, "_hold_hi"}, bus.out_hi, ehi);
      chk({name, "_hold_ready"}, bus.in_ready, 0);
    end
    if (flush_done) bus.flush = 1'b1;
    else            bus.out_stall = 1'b0;
    @(posedge clk);
    #1;
    bus.flush     = 1'b0;
    bus.out_stall = 1'b0;
    @(negedge clk);
    chk({name, "_drop"}, bus.out_valid, 0);
    chk({name, "_ready_again"}, bus.in_ready, 1);
    last_lo = elo;
    last_hi = ehi;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_tag    = '0;
    bus.flush     = 1'b0;
    bus.out_stall = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_lo", bus.out_lo, 0);
    chk("rst_hi", bus.out_hi, 0);
    chk("rst_tag", bus.out_tag, 0);
    chk("rst_dz", bus.out_div_zero, 0);
    reset = 1'b1;

    run_op("mulu_7x6",   2'b00, 32'h7,          32'h6,          7'h45, 0, 1'b0);
    run_op("muls_neg",   2'b01, 32'hFFFF_FFFD,  32'h5,          7'h12, 0, 1'b0);
    run_op("muls_min",   2'b01, 32'h8000_0000,  32'h8000_0000,  7'h01, 0, 1'b0);
    run_op("divu_100_7", 2'b10, 32'd100,        32'd7,          7'h22, 0, 1'b0);
    run_op("divs_m7_2",  2'b11, 32'hFFFF_FFF9,  32'h2,          7'h33, 0, 1'b0);
    run_op("divs_ovf",   2'b11, 32'h8000_0000,  32'hFFFF_FFFF,  7'h44, 0, 1'b0);
    run_op("divu_5_0",   2'b10, 32'h5,          32'h0,          7'h55, 0, 1'b0);
    run_op("divs_m9_0",  2'b11, 32'hFFFF_FFF7,  32'h0,          7'h56, 0, 1'b0);
    run_op("stall5",     2'b00, 32'h1234_5678,  32'h9ABC_DEF0,  7'h66, 5, 1'b0);

    // Flush while BUSY with count at 10: squashed, outputs keep the previous result.
    @(negedge clk);
    drive_op(2'b01, 32'h0000_0011, 32'h0000_0013, 7'h77);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (WIDTH - 10) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_busy_ready", bus.in_ready, 1);
    chk("flush_busy_keep_lo", bus.out_lo, last_lo);
    chk("flush_busy_keep_hi", bus.out_hi, last_hi);
    quiet("flush_busy_quiet", WIDTH + 10);

    // Flush together with in_valid in IDLE: nothing is accepted.
    @(negedge clk);
    drive_op(2'b00, 32'h3, 32'h3, 7'h11);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    @(negedge clk);
    chk("flush_idle_ready", bus.in_ready, 1);
    quiet("flush_idle_quiet", WIDTH + 10);

    run_op("flush_done", 2'b10, 32'd1000, 32'd33, 7'h5A, 2, 1'b1);

    for (int i = 0; i < 24; i++) begin
      run_op($sformatf("rnd%0d", i), 2'($urandom_range(0, 3)), pick(), pick(),
             7'($urandom_range(0, 127)), $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
    end

    // Reset in the middle of BUSY: everything clears and no stale result follows.
    @(negedge clk);
    drive_op(2'b00, 32'h7, 32'h6, 7'h45);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_valid", bus.out_valid, 0);
    chk("midrst_lo", bus.out_lo, 0);
    chk("midrst_hi", bus.out_hi, 0);
    chk("midrst_tag", bus.out_tag, 0);
    chk("midrst_dz", bus.out_div_zero, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_ready", bus.in_ready, 1);
    quiet("midrst_quiet", WIDTH + 10);

    run_op("after_rst", 2'b11, 32'hFFFF_FF9C, 32'h7, 7'h2B, 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
